// File: rtl/buffer_reader.sv
// buffer_reader: read-side controller for the parallel Buffer.
// Tracks occupancy and streams sliding PAR_READ-entry windows.
module buffer_reader #(
  parameter int SIZE        = 4,
  parameter int MEM_SIZE    = 4,
  parameter int PAR_WRITE   = 2,
  parameter int PAR_READ    = 4,
  parameter int STRIDE      = 2,
  parameter int ADDRES_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic                     err,
  output logic [ADDRES_SIZE-1:0]   raddr,
  input  logic [PAR_READ*SIZE-1:0] buf_dout,
  output logic [PAR_READ*SIZE-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = ADDRES_SIZE + 1;

  localparam logic [CW-1:0] CNT_PW   = CW'(PAR_WRITE);
  localparam logic [CW-1:0] CNT_PR   = CW'(PAR_READ);
  localparam logic [CW-1:0] CNT_ST   = CW'(STRIDE);
  localparam logic [CW-1:0] CNT_HIGH = CW'(MEM_SIZE - PAR_WRITE);

  localparam logic [ADDRES_SIZE-1:0] PTR_ST = ADDRES_SIZE'(STRIDE);

  logic [ADDRES_SIZE-1:0] rptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_nxt;
  logic                   push;
  logic                   load;

  assign full  = count > CNT_HIGH;
  assign empty = count == '0;
  assign raddr = rptr;

  assign push = wen & ~full;
  assign load = ~flush & (count >= CNT_PR)
              & (~out_valid | out_ready);

  // next occupancy: pushes add, loads retire, flush drops all
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = push ? CNT_PW : '0;
    end else begin
      count_nxt = count
                + (push ? CNT_PW : '0)
                - (load ? CNT_ST : '0);
    end
  end

  // pointer, occupancy and output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wen & full)
        err <= 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        rptr      <= rptr + count[ADDRES_SIZE-1:0];
      end else if (load) begin
        out_data  <= buf_dout;
        out_valid <= 1'b1;
        rptr      <= rptr + PTR_ST;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: queue-model check of buffer_reader.
// Directed fill/hold/wrap/overflow/flush, then random traffic.
module tb_buffer_reader;

  localparam int SZ  = 4;
  localparam int MEM = 4;
  localparam int PW  = 2;
  localparam int PR  = 4;
  localparam int ST  = 2;
  localparam int AW  = $clog2(MEM);

  logic             clk;
  logic             rst;
  logic             wen;
  logic             flush;
  logic             full;
  logic             empty;
  logic             err;
  logic [AW-1:0]    raddr;
  logic [PR*SZ-1:0] buf_dout;
  logic [PR*SZ-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  buffer_reader #(
    .SIZE(SZ), .MEM_SIZE(MEM), .PAR_WRITE(PW),
    .PAR_READ(PR), .STRIDE(ST)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .flush(flush),
    .full(full), .empty(empty), .err(err),
    .raddr(raddr), .buf_dout(buf_dout),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer storage written by the bench-side writer
  logic [SZ-1:0] mem [MEM];
  logic          mem_we;
  int            wa0, wa1;
  logic [SZ-1:0] wd0, wd1;

  always @(posedge clk)
    if (mem_we) begin
      mem[wa0] <= wd0;
      mem[wa1] <= wd1;
    end

  always_comb begin
    buf_dout = '0;
    for (int i = 0; i < PR; i++)
      buf_dout[i*SZ +: SZ] = mem[(int'(raddr) + i) % MEM];
  end

  // reference model: FIFO of stored entries plus retired total
  logic [SZ-1:0]    q [$];
  int               rbase;
  logic             mv;
  logic [PR*SZ-1:0] md;
  logic             merr;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    rbase = 0;
    mv    = 1'b0;
    md    = '0;
    merr  = 1'b0;
  endtask

  // enter at negedge: check state, drive inputs, advance model
  task automatic step(input logic w, input logic f,
                      input logic r,
                      input logic [SZ-1:0] d0,
                      input logic [SZ-1:0] d1);
    logic mfull;
    logic mpush;
    chk("full", 32'(full), 32'(q.size() > MEM - PW));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("err", 32'(err), 32'(merr));
    chk("raddr", 32'(raddr), 32'(rbase % MEM));
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("out_data", 32'(out_data), 32'(md));
    wen       = w;
    flush     = f;
    out_ready = r;
    mfull = q.size() > MEM - PW;
    mpush = w && !mfull;
    if (w && mfull)
      merr = 1'b1;
    if (f) begin
      rbase += q.size();
      q.delete();
      mv = 1'b0;
    end else if (q.size() >= PR && (!mv || r)) begin
      for (int i = 0; i < PR; i++)
        md[i*SZ +: SZ] = q[i];
      mv = 1'b1;
      for (int i = 0; i < ST; i++)
        void'(q.pop_front());
      rbase += ST;
    end else if (mv && r) begin
      mv = 1'b0;
    end
    mem_we = mpush;
    wa0    = (rbase + q.size()) % MEM;
    wa1    = (rbase + q.size() + 1) % MEM;
    wd0    = d0;
    wd1    = d1;
    if (mpush) begin
      q.push_back(d0);
      q.push_back(d1);
    end
    @(negedge clk);
  endtask

  // caller is at a negedge; leaves at a negedge with rst low
  task automatic do_reset();
    rst       = 1'b1;
    wen       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mem_we    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    wen       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    mem_we    = 1'b0;
    wa0 = 0; wa1 = 1; wd0 = '0; wd1 = '0;
    for (int i = 0; i < MEM; i++)
      mem[i] = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // fill 1,2,3,4 and hold first window
    step(1, 0, 0, 4'd1, 4'd2);
    step(1, 0, 0, 4'd3, 4'd4);
    repeat (6) step(0, 0, 0, 0, 0);
    chk("first_window", 32'(out_data), 32'h4321);
    step(0, 0, 1, 0, 0);

    // wrap: entries 0,1 = 5,6
    step(1, 0, 0, 4'd5, 4'd6);
    step(0, 0, 0, 0, 0);
    chk("wrap_window", 32'(out_data), 32'h6543);
    chk("wrap_raddr", 32'(raddr), 32'd0);
    step(0, 0, 1, 0, 0);

    // overflow then flush with push
    step(1, 0, 0, 4'd7, 4'd8);
    step(1, 0, 0, 4'd9, 4'd9);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 4'd10, 4'd11);
    step(1, 0, 0, 4'd12, 4'd13);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("err_sticky", 32'(err), 32'd1);

    // random traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 2) != 0),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      end
    end

    do_reset();
    step(0, 0, 0, 0, 0);
    chk("err_cleared", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
